bfu_pipe_param: RTL

Parametrised, elastic NTT/INTT butterfly. It replaces the fixed-width, free-running butterfly with valid/ready flow control, a configurable modulus and width, and a configurable multiplier latency. Mode is selected per sample, and optional INTT halving by 2^-1 mod Q is built in. It sits between the coefficient-memory read port and the write-back path of the NTT engine.

---
 rtl/bfu_pkg.sv | 40 ++++
 rtl/mod_mul_pipe.sv | 57 +++++
 rtl/bfu_pipe_param.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bfu_pkg.sv
// Shared constants and modular-arithmetic helpers for the parametrised butterfly.
package bfu_pkg;

  localparam int W_DEF = 12;
  localparam int Q_DEF = 3329;
  localparam int MAX_W = 32;

  localparam logic MODE_NTT  = 1'b0;
  localparam logic MODE_INTT = 1'b1;

  typedef logic [MAX_W-1:0] coef_t;

  function automatic logic [63:0] barrett_mu(input int w, input int q);
    logic [63:0] qq;
    qq = 64'(q);
    return (64'd1 << (2 * w)) / qq;
  endfunction

  // Operands must already lie in [0, q-1]; one conditional correction suffices.
  function automatic coef_t mod_add(input coef_t a, input coef_t b, input coef_t q);
    logic [MAX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[MAX_W-1:0];
  endfunction

  function automatic coef_t mod_sub(input coef_t a, input coef_t b, input coef_t q);
    logic [MAX_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[MAX_W]) d = d + {1'b0, q};
    return d[MAX_W-1:0];
  endfunction

  function automatic coef_t mod_half(input coef_t x, input coef_t q);
    logic [MAX_W:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
    return s[MAX_W:1];
  endfunction

endpackage

// File: rtl/mod_mul_pipe.sv
// Barrett modular multiplier, p = (x*y) mod Q, exactly MUL_LAT enabled cycles deep.
module mod_mul_pipe
  import bfu_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int Q       = Q_DEF,
  parameter int MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] p
);

  localparam logic [2*W:0] MU = (2*W+1)'(barrett_mu(W, Q));
  localparam logic [W+1:0] QX = (W+2)'(Q);

  logic [2*W-1:0] prod_q;
  logic [W+1:0]   qhat_lo;
  logic [W+1:0]   r;
  logic [W-1:0]   red;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prod_q <= '0;
    else if (en) prod_q <= {{W{1'b0}}, x} * {{W{1'b0}}, y};
  end

  // Barrett estimate undershoots by at most 2, and the remainder is below 4Q,
  // so only the low W+2 bits of qhat*Q matter.
  always_comb begin
    qhat_lo = (W+2)'(({{(2*W+1){1'b0}}, prod_q} * {{(2*W){1'b0}}, MU}) >> (2*W));
    r = prod_q[W+1:0] - qhat_lo * QX;
    if (r >= QX) r = r - QX;
    if (r >= QX) r = r - QX;
    red = r[W-1:0];
  end

  generate
    if (MUL_LAT == 1) begin : g_direct
      assign p = red;
    end else begin : g_pipe
      logic [W-1:0] stage [MUL_LAT-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < MUL_LAT - 1; i++) stage[i] <= '0;
        end else if (en) begin
          stage[0] <= red;
          for (int i = 1; i < MUL_LAT - 1; i++) stage[i] <= stage[i-1];
        end
      end
      assign p = stage[MUL_LAT-2];
    end
  endgenerate

endmodule

// File: rtl/bfu_pipe_param.sv
// Elastic NTT/INTT butterfly with per-sample mode, tag sideband and sticky range error.
module bfu_pipe_param
  import bfu_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int Q          = Q_DEF,
  parameter int MUL_LAT    = 3,
  parameter bit HALVE_INTT = 1'b1,
  parameter int TAG_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W-1:0]     in_twf,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_up,
  output logic [W-1:0]     out_dn,
  output logic [TAG_W-1:0] out_tag,
  output logic             range_err,
  output logic             busy
);

  localparam coef_t        QC = coef_t'(Q);
  localparam logic [W-1:0] QW = W'(Q);

  typedef struct packed {
    logic             vld;
    logic             mode;
    logic             oor;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     a;
    logic [W-1:0]     sum;
  } side_t;

  side_t        s0;
  side_t        dly [MUL_LAT];
  side_t        last;
  logic [W-1:0] s0_op, s0_twf, p;
  logic [W-1:0] in_sum, in_diff, up_next, dn_next;
  logic         adv, fire, in_oor;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && rst_n;
  assign fire     = in_valid && in_ready;
  assign in_oor   = (in_a >= QW) || (in_b >= QW) || (in_twf >= QW);
  assign in_sum   = W'(mod_add(MAX_W'(in_a), MAX_W'(in_b), QC));
  assign in_diff  = W'(mod_sub(MAX_W'(in_b), MAX_W'(in_a), QC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0     <= '0;
      s0_op  <= '0;
      s0_twf <= '0;
    end else if (adv) begin
      s0.vld  <= fire;
      s0.mode <= in_mode;
      s0.oor  <= in_oor;
      s0.tag  <= in_tag;
      s0.a    <= in_a;
      s0.sum  <= in_sum;
      s0_op   <= (in_mode == MODE_INTT) ? in_diff : in_b;
      s0_twf  <= in_twf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) range_err <= 1'b0;
    else if (fire && in_oor) range_err <= 1'b1;
  end

  mod_mul_pipe #(
    .W       (W),
    .Q       (Q),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .x     (s0_op),
    .y     (s0_twf),
    .p     (p)
  );

  // Sideband rides alongside the multiplier so dly[MUL_LAT-1] lines up with p.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) dly[i] <= '0;
    end else if (adv) begin
      dly[0] <= s0;
      for (int i = 1; i < MUL_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign last = dly[MUL_LAT-1];

  always_comb begin
    up_next = '0;
    dn_next = '0;
    if (last.mode == MODE_NTT) begin
      up_next = W'(mod_add(MAX_W'(last.a), MAX_W'(p), QC));
      dn_next = W'(mod_sub(MAX_W'(last.a), MAX_W'(p), QC));
    end else begin
      up_next = last.sum;
      dn_next = p;
      if (HALVE_INTT) begin
        up_next = W'(mod_half(MAX_W'(last.sum), QC));
        dn_next = W'(mod_half(MAX_W'(p), QC));
      end
    end
    if (last.oor) begin
      up_next = '0;
      dn_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_up    <= '0;
      out_dn    <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= last.vld;
      out_up    <= up_next;
      out_dn    <= dn_next;
      out_tag   <= last.tag;
    end
  end

  always_comb begin
    busy = s0.vld | out_valid;
    for (int i = 0; i < MUL_LAT; i++) busy = busy | dly[i].vld;
  end

endmodule
